// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin scheduler.
package wrr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  function automatic int unsigned wrap_inc(input int unsigned id, input int unsigned n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

  // A zero weight would starve the channel, so it is served as a quantum of one.
  function automatic int unsigned eff_quantum(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/wrr_scheduler_rr_pick.sv
// Rotating find-first-set: first asserted req at start, start+1, ... mod NUM_CH.
module rr_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ID_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   start,
  output logic              found,
  output logic [ID_W-1:0]   idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    idx   = start;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!found && req[ID_W'((32'(start) + k) % NUM_CH)]) begin
        found = 1'b1;
        idx   = ID_W'((32'(start) + k) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/wrr_scheduler.sv
// Weighted round-robin scheduler draining NUM_CH FIFOs into one ready/valid consumer.
module wrr_scheduler
  import wrr_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned ID_W     = $clog2(NUM_CH),
  parameter int unsigned WEIGHT_W = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            empty,
  input  logic [NUM_CH*WEIGHT_W-1:0]   weight,
  input  logic                         ready,
  output logic                         valid,
  output logic [ID_W-1:0]              id,
  output logic [NUM_CH-1:0]            pop,
  output logic                         busy
);

  state_e               state_q;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      id_q;
  logic [WEIGHT_W-1:0]  cnt_q;
  logic [WEIGHT_W-1:0]  quantum_q;

  logic [ID_W-1:0]      id_inc;
  logic [ID_W-1:0]      search_start;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_idx;
  logic [WEIGHT_W-1:0]  pick_weight;
  logic [WEIGHT_W-1:0]  pick_quantum;
  logic                 xfer;
  logic                 end_of_burst;

  assign id_inc = ID_W'(wrap_inc(32'(id_q), NUM_CH));

  // Starting the SERVE search at id+1 puts the current channel last in line.
  assign search_start = (state_q == IDLE) ? ptr_q : id_inc;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .req    (~empty),
    .start  (search_start),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign pick_weight  = weight[32'(pick_idx)*WEIGHT_W +: WEIGHT_W];
  assign pick_quantum = WEIGHT_W'(eff_quantum(32'(pick_weight)));

  assign valid        = (state_q == SERVE) && enable && !empty[id_q];
  assign xfer         = valid && ready;
  assign pop          = xfer ? (NUM_CH'(1) << id_q) : '0;
  assign busy         = (state_q == SERVE);
  assign id           = id_q;
  assign end_of_burst = (xfer && (cnt_q == quantum_q - WEIGHT_W'(1))) || empty[id_q];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      quantum_q <= WEIGHT_W'(1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && pick_found) begin
            state_q   <= SERVE;
            id_q      <= pick_idx;
            cnt_q     <= '0;
            quantum_q <= pick_quantum;
          end
        end
        SERVE: begin
          if (enable) begin
            if (end_of_burst) begin
              ptr_q <= id_inc;
              if (pick_found) begin
                id_q      <= pick_idx;
                cnt_q     <= '0;
                quantum_q <= pick_quantum;
              end else begin
                state_q <= IDLE;
              end
            end else if (xfer) begin
              cnt_q <= cnt_q + WEIGHT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_scheduler.sv
// Randomised and directed bench for wrr_scheduler against a burst-level reference model.
module tb_wrr_scheduler;

  localparam int NUM_CH   = 4;
  localparam int ID_W     = 2;
  localparam int WEIGHT_W = 3;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       enable;
  logic [NUM_CH-1:0]          empty;
  logic [NUM_CH*WEIGHT_W-1:0] weight;
  logic                       ready;
  logic                       valid;
  logic [ID_W-1:0]            id;
  logic [NUM_CH-1:0]          pop;
  logic                       busy;

  wrr_scheduler #(
    .NUM_CH   (NUM_CH),
    .ID_W     (ID_W),
    .WEIGHT_W (WEIGHT_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .empty  (empty),
    .weight (weight),
    .ready  (ready),
    .valid  (valid),
    .id     (id),
    .pop    (pop),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // FIFO bank model: word counts; empty follows the count, so it rises the cycle after the last pop.
  int fifo_cnt [NUM_CH];
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) empty[i] = (fifo_cnt[i] == 0);
  end

  // Reference model: which channel owns the line, how many words its burst may still move,
  // and where the next round-robin scan begins.
  bit m_active;
  int m_cur;
  int m_ptr;
  int m_rem;

  int n_checks = 0;
  int n_pass   = 0;
  int pop_log[$];

  int exp_seq3 [14] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
  int exp_seq4 [4]  = '{0, 0, 0, 1};
  int exp_seq6 [5]  = '{0, 1, 2, 3, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int quantum_of(input int ch);
    logic [WEIGHT_W-1:0] w;
    w = weight[ch*WEIGHT_W +: WEIGHT_W];
    return (w == 0) ? 1 : int'(w);
  endfunction

  function automatic int find_from(input int start);
    for (int k = 0; k < NUM_CH; k++) begin
      if (fifo_cnt[(start + k) % NUM_CH] > 0) return (start + k) % NUM_CH;
    end
    return -1;
  endfunction

  function automatic void model_start(input int ch);
    m_active = 1'b1;
    m_cur    = ch;
    m_rem    = quantum_of(ch);
  endfunction

  // One clock: check at negedge, advance the model, let the edge pass, then retire the popped word.
  task automatic cycle();
    bit ev;
    bit do_xfer;
    int ep;
    int xch;
    int nxt;
    @(negedge clk);
    ev      = m_active && enable && (fifo_cnt[m_cur] > 0);
    do_xfer = ev && ready;
    ep      = do_xfer ? (1 << m_cur) : 0;
    check("valid", 32'(valid), 32'(ev));
    check("pop",   32'(pop),   32'(ep));
    check("busy",  32'(busy),  32'(m_active));
    check("id",    32'(id),    32'(m_cur));
    if (pop != '0) pop_log.push_back(int'(id));
    xch = m_cur;
    if (!m_active) begin
      if (enable) begin
        nxt = find_from(m_ptr);
        if (nxt >= 0) model_start(nxt);
      end
    end else if (enable) begin
      if (do_xfer) m_rem--;
      if ((do_xfer && m_rem == 0) || fifo_cnt[m_cur] == 0) begin
        m_ptr = (m_cur + 1) % NUM_CH;
        nxt   = find_from(m_ptr);
        if (nxt >= 0) model_start(nxt);
        else m_active = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (do_xfer) fifo_cnt[xch]--;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_pop",   32'(pop),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_id",    32'(id),    32'd0);
    m_active = 1'b0;
    m_cur    = 0;
    m_ptr    = 0;
    m_rem    = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weight = {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
  endtask

  task automatic fill(input int c0, input int c1, input int c2, input int c3);
    fifo_cnt[0] = c0;
    fifo_cnt[1] = c1;
    fifo_cnt[2] = c2;
    fifo_cnt[3] = c3;
  endtask

  task automatic check_log(input string tag, input int idx, input int exp);
    if (idx < pop_log.size()) check(tag, 32'(pop_log[idx]), 32'(exp));
    else check(tag, 32'hdead, 32'(exp));
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    ready  = 1'b0;
    weight = '0;
    fill(0, 0, 0, 0);
    #2;
    do_reset();

    // Equal weights: plain rotation.
    fill(100, 100, 100, 100);
    set_w(1, 1, 1, 1);
    enable = 1'b1;
    ready  = 1'b1;
    repeat (14) cycle();

    // Weights {3,1,2,0}: 0,0,0,1,2,2,3 repeating.
    do_reset();
    fill(100, 100, 100, 100);
    set_w(3, 1, 2, 0);
    pop_log.delete();
    repeat (15) cycle();
    check("seq3_len", 32'(pop_log.size()), 32'd14);
    for (int i = 0; i < 14; i++) check_log("seq3", i, exp_seq3[i]);

    // Backpressure inside a ch0 burst of three.
    do_reset();
    fill(100, 100, 100, 100);
    set_w(3, 1, 1, 1);
    pop_log.delete();
    repeat (2) cycle();
    ready = 1'b0;
    repeat (5) cycle();
    ready = 1'b1;
    repeat (4) cycle();
    for (int i = 0; i < 4; i++) check_log("seq4", i, exp_seq4[i]);

    // Only ch2 holds three words, weight 2.
    do_reset();
    fill(0, 0, 3, 0);
    set_w(1, 1, 2, 1);
    pop_log.delete();
    repeat (6) cycle();
    check("seq5_len", 32'(pop_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_log("seq5", i, 2);

    // ch0 drains on its first word mid-burst.
    do_reset();
    fill(1, 50, 50, 50);
    set_w(3, 1, 1, 1);
    pop_log.delete();
    repeat (8) cycle();
    for (int i = 0; i < 5; i++) check_log("seq6", i, exp_seq6[i]);

    // Reset in the middle of a ch1 burst after one word.
    do_reset();
    fill(100, 100, 100, 100);
    set_w(1, 3, 1, 1);
    begin
      int guard = 0;
      while (!(m_active && m_cur == 1 && m_rem == 2) && guard < 20) begin
        cycle();
        guard++;
      end
      check("midburst_reached", 32'(guard < 20), 32'd1);
    end
    do_reset();
    pop_log.delete();
    repeat (3) cycle();
    check_log("after_reset_first", 0, 0);

    // Randomised traffic, backpressure, pauses, weight changes and resets.
    do_reset();
    fill(3, 0, 5, 1);
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(9) != 0);
      ready  = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) weight = 12'($urandom);
      if ($urandom_range(399) == 0) do_reset();
      cycle();
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(5) == 0) fifo_cnt[i] += $urandom_range(3, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
